// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, default frame geometry, vote point helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Defaults match the clock-divider stage feeding the receiver.
    localparam int SAMPLE_RATE_DEF = 10;
    localparam int DATA_BITS_DEF   = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // Centre sample of a bit; the vote window is M-1, M, M+1.
    function automatic int mid_sample(input int sample_rate);
        return sample_rate / 2;
    endfunction

endpackage

// File: rtl/uart_bit_voter.sv
// Majority voter over the three mid-bit samples of the current bit.
// Latency: bit_val is valid combinationally during the tick at M+1 (third sample is the live rx_s).
// Backpressure: none; captures only when sample_en is high.
module uart_bit_voter
    import uart_pkg::*;
#(
    parameter int SAMPLE_RATE = SAMPLE_RATE_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_en,
    input  logic                           rx_s,
    input  logic [$clog2(SAMPLE_RATE)-1:0] tick_cnt,
    output logic                           bit_val
);

    localparam int                CNT_W  = $clog2(SAMPLE_RATE);
    localparam int                M      = mid_sample(SAMPLE_RATE);
    localparam logic [CNT_W-1:0]  VOTE_A = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0]  VOTE_B = CNT_W'(M);

    // Samples from M-1 and M; the M+1 sample is taken straight from rx_s so
    // the decision is available on the same tick that carries it.
    logic [1:0] samp;

    // Capture the first two vote samples of each bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp <= 2'b00;
        end else if (sample_en) begin
            if (tick_cnt == VOTE_A) samp[0] <= rx_s;
            if (tick_cnt == VOTE_B) samp[1] <= rx_s;
        end
    end

    assign bit_val = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver on an oversampling tick enable: sync, start detect, mid-bit vote, stop check.
// Latency: 2 clk synchroniser; rx_valid rises 1 clk after the tick carrying stop-bit sample M+1.
// Backpressure: rx_valid held until rx_ack; a good frame arriving while full is dropped with overrun_err.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int SAMPLE_RATE = SAMPLE_RATE_DEF,
    parameter int DATA_BITS   = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int               CNT_W    = $clog2(SAMPLE_RATE);
    localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(mid_sample(SAMPLE_RATE) + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_RATE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_m, rx_s;
    rx_state_t            state, state_nxt;
    logic [CNT_W-1:0]     tick_cnt, tick_cnt_nxt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 bit_val;
    logic                 voter_en;
    logic                 stop_good, stop_bad;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign voter_en = sample_tick && (state == START || state == DATA || state == STOP);

    uart_bit_voter #(
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_voter (
        .clk       (clk),
        .rst       (rst),
        .sample_en (voter_en),
        .rx_s      (rx_s),
        .tick_cnt  (tick_cnt),
        .bit_val   (bit_val)
    );

    // Frame state, counters and shift register advance only on sample ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shift    <= shift_nxt;
        end
    end

    // Next-state: walk start, data and stop bits; stop is judged mid-bit to resync early.
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift;
        stop_good    = 1'b0;
        stop_bad     = 1'b0;
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        // The detection tick is sample 0 of the start bit.
                        tick_cnt_nxt = CNT_W'(1);
                        state_nxt    = START;
                    end
                end
                START: begin
                    tick_cnt_nxt = tick_cnt + 1'b1;
                    if (tick_cnt == CNT_VOTE && bit_val) begin
                        tick_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end else if (tick_cnt == CNT_LAST) begin
                        tick_cnt_nxt = '0;
                        bit_idx_nxt  = '0;
                        state_nxt    = DATA;
                    end
                end
                DATA: begin
                    tick_cnt_nxt = tick_cnt + 1'b1;
                    if (tick_cnt == CNT_VOTE) begin
                        // LSB arrives first, so shift in from the top.
                        shift_nxt = {bit_val, shift[DATA_BITS-1:1]};
                    end
                    if (tick_cnt == CNT_LAST) begin
                        tick_cnt_nxt = '0;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx_nxt = '0;
                            state_nxt   = STOP;
                        end else begin
                            bit_idx_nxt = bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    tick_cnt_nxt = tick_cnt + 1'b1;
                    if (tick_cnt == CNT_VOTE) begin
                        tick_cnt_nxt = '0;
                        if (bit_val) begin
                            stop_good = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            stop_bad  = 1'b1;
                            state_nxt = WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // Hold off through a break so it reports only once.
                    if (rx_s) state_nxt = IDLE;
                end
                default: begin
                    state_nxt    = IDLE;
                    tick_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Output handshake runs every clk; an ack in the completion clk frees the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= stop_bad;
            overrun_err <= 1'b0;
            if (stop_good) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Randomised scoreboard bench for uart_rx_sampler with a per-sample line model.
// Latency: stimulus issues one sample slot per 4 clk; checks happen on the falling edge.
// Backpressure: monitor acks after a random delay; directed phases drive ack by hand.
module tb_uart_rx_sampler;

    localparam int SR    = 10;
    localparam int DB    = 8;
    localparam int M     = SR / 2;
    localparam int NSLOT = SR * (DB + 2);
    localparam int STOP_VOTE_SLOT = SR * (DB + 1) + M + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx = 1'b1;
    logic       mon_ack = 1'b0;
    logic       man_ack = 1'b0;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;

    assign rx_ack = mon_ack | man_ack;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int exp_fe   = 0;
    int exp_ov   = 0;
    bit mon_en   = 1'b0;
    bit sb_on    = 1'b0;
    logic [7:0] exp_q[$];
    bit fr [0:NSLOT-1];

    uart_rx_sampler #(
        .SAMPLE_RATE (SR),
        .DATA_BITS   (DB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit maj3(input bit a, input bit b, input bit c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    // Error pulses are one clk wide, so one falling-edge sample counts each once.
    always @(negedge clk) begin
        if (frame_err === 1'b1)   fe_cnt++;
        if (overrun_err === 1'b1) ov_cnt++;
    end

    // Scoreboard monitor: compare each presented byte, then ack after a random delay.
    initial begin : monitor
        bit got;
        int dly;
        got = 1'b0;
        dly = 0;
        forever begin
            @(negedge clk);
            if (mon_ack) begin
                mon_ack = 1'b0;
                check("ack_clears_valid", rx_valid, 1'b0);
            end else if (mon_en && rx_valid) begin
                if (!got) begin
                    got = 1'b1;
                    dly = $urandom_range(0, 5);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got 0x%0h expected no byte", rx_data);
                    end else begin
                        check("rx_data", rx_data, exp_q.pop_front());
                    end
                end
                if (dly == 0) begin
                    mon_ack = 1'b1;
                    got     = 1'b0;
                end else begin
                    dly--;
                end
            end
        end
    end

    // One oversampling slot: rx settles, then a single tick 3 clk later.
    task automatic send_slot(input bit v, input bit ack);
        rx          = v;
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        sample_tick = 1'b1;
        man_ack     = ack;
        @(negedge clk);
        sample_tick = 1'b0;
        man_ack     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_slot(1'b1, 1'b0);
    endtask

    task automatic fill_frame(input logic [7:0] d, input bit stop_v);
        for (int b = 0; b < DB + 2; b++)
            for (int k = 0; k < SR; k++)
                fr[b*SR + k] = (b == 0) ? 1'b0 : (b == DB + 1) ? stop_v : d[b-1];
    endtask

    // Reference: each bit is the majority of its mid samples; frame outcome from start/stop votes.
    task automatic send_frame(input bit lat_chk, input bit ack_stop);
        bit         start_ok, stop_ok;
        logic [7:0] exp;
        start_ok = !maj3(fr[M-1], fr[M], fr[M+1]);
        for (int b = 0; b < DB; b++)
            exp[b] = maj3(fr[(b+1)*SR + M-1], fr[(b+1)*SR + M], fr[(b+1)*SR + M+1]);
        stop_ok = maj3(fr[(DB+1)*SR + M-1], fr[(DB+1)*SR + M], fr[(DB+1)*SR + M+1]);
        if (start_ok && stop_ok && sb_on) exp_q.push_back(exp);
        if (start_ok && !stop_ok) exp_fe++;
        for (int s = 0; s < NSLOT; s++) begin
            send_slot(fr[s], ack_stop && (s == STOP_VOTE_SLOT));
            if (lat_chk && s == STOP_VOTE_SLOT - 1) check("valid_before_stop", rx_valid, 1'b0);
            if (lat_chk && s == STOP_VOTE_SLOT)     check("valid_latency", rx_valid, 1'b1);
        end
    endtask

    task automatic do_ack();
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check("manual_ack_clears", rx_valid, 1'b0);
    endtask

    initial begin : main
        logic [7:0] d;
        bit         stop_v;
        int         b, k, k2, g;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun_err", overrun_err, 1'b0);
        rst = 1'b1;
        idle(3);

        // 1: basic frame with latency check
        mon_en = 1'b1;
        sb_on  = 1'b1;
        fill_frame(8'hA5, 1'b1);
        send_frame(1'b1, 1'b0);
        idle(3);

        // 2: start glitch then a real frame
        for (int i = 0; i < 3; i++) send_slot(1'b0, 1'b0);
        idle(12);
        check("glitch_no_valid", rx_valid, 1'b0);
        check("glitch_no_frame_err", fe_cnt, exp_fe);
        fill_frame(8'h3C, 1'b1);
        send_frame(1'b0, 1'b0);
        idle(3);

        // 3: framing error, break, recovery
        fill_frame(8'h55, 1'b0);
        send_frame(1'b0, 1'b0);
        for (int i = 0; i < 30; i++) send_slot(1'b0, 1'b0);
        idle(2);
        check("break_single_frame_err", fe_cnt, exp_fe);
        check("break_no_valid", rx_valid, 1'b0);
        fill_frame(8'h0F, 1'b1);
        send_frame(1'b0, 1'b0);
        idle(3);

        // 5: mid-bit glitches on data bit 3
        fill_frame(8'h00, 1'b1);
        fr[4*SR + 5] = ~fr[4*SR + 5];
        send_frame(1'b0, 1'b0);
        idle(2);
        fill_frame(8'h00, 1'b1);
        fr[4*SR + 4] = ~fr[4*SR + 4];
        fr[4*SR + 5] = ~fr[4*SR + 5];
        send_frame(1'b0, 1'b0);
        idle(3);

        // 4: overrun, then ack in the stop completion clk
        mon_en = 1'b0;
        sb_on  = 1'b0;
        idle(2);
        fill_frame(8'h11, 1'b1);
        send_frame(1'b0, 1'b0);
        fill_frame(8'h22, 1'b1);
        send_frame(1'b0, 1'b0);
        exp_ov++;
        idle(1);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_pulse", ov_cnt, exp_ov);
        do_ack();
        fill_frame(8'h11, 1'b1);
        send_frame(1'b0, 1'b0);
        fill_frame(8'h22, 1'b1);
        send_frame(1'b0, 1'b1);
        idle(1);
        check("ack_same_clk_valid", rx_valid, 1'b1);
        check("ack_same_clk_data", rx_data, 8'h22);
        check("ack_same_clk_no_ovr", ov_cnt, exp_ov);
        do_ack();

        // 6: async reset mid data bit 4
        fill_frame(8'h5A, 1'b1);
        send_frame(1'b0, 1'b0);
        check("pre_rst_valid", rx_valid, 1'b1);
        fill_frame(8'hFF, 1'b1);
        for (int s = 0; s < 5*SR + 5; s++) send_slot(fr[s], 1'b0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", rx_valid, 1'b0);
        check("async_rst_data", rx_data, 8'h00);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2);
        mon_en = 1'b1;
        sb_on  = 1'b1;
        fill_frame(8'hC3, 1'b1);
        send_frame(1'b0, 1'b0);
        idle(3);

        // Random frames with vote-window glitches and occasional bad stop bits
        repeat (30) begin
            d      = 8'($urandom);
            stop_v = ($urandom_range(0, 5) != 0);
            fill_frame(d, stop_v);
            g = $urandom_range(0, 2);
            b = $urandom_range(1, DB);
            if (g == 1) begin
                k = $urandom_range(1, SR - 1);
                fr[b*SR + k] = ~fr[b*SR + k];
            end else if (g == 2) begin
                k  = $urandom_range(M - 1, M + 1);
                k2 = (k == M + 1) ? M - 1 : k + 1;
                fr[b*SR + k]  = ~fr[b*SR + k];
                fr[b*SR + k2] = ~fr[b*SR + k2];
            end
            send_frame(1'b0, 1'b0);
            idle(stop_v ? $urandom_range(0, 3) : $urandom_range(1, 4));
        end
        repeat (20) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        check("frame_err_total", fe_cnt, exp_fe);
        check("overrun_total", ov_cnt, exp_ov);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- 8N1 UART receiver driven by the 10x oversampling tick from the clock-divider stage; sits directly downstream of it in the UART path.
- Synchronises the serial rx line and detects the start bit.
- Takes a 3-sample majority vote at mid-bit, assembles the LSB-first data byte, and checks the stop bit.
- Presents the byte on a valid/ack handshake to the image-processing side.
- Single clock domain: the divider's sampling clock enters only as a one-cycle enable, never as a clock.

Parameters:
SAMPLE_RATE, 10, sample ticks per bit period; must be ≥ 4 (counter width clog2(SAMPLE_RATE))
DATA_BITS, 8, data bits per frame; LSB first

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
sample_tick  in  1  one-clk-wide enable, SAMPLE_RATE pulses per bit period, synchronous to clk
rx  in  1  raw serial line, idle high, asynchronous
rx_data  out  DATA_BITS  last good byte; stable while rx_valid=1
rx_valid  out  1  byte available; held until acked
rx_ack  in  1  consumer takes byte; effective only when rx_valid=1
frame_err  out  1  one-clk pulse: stop bit sampled low
overrun_err  out  1  one-clk pulse: good frame completed while rx_valid=1

Behaviour:
- Reset (rst=0, async) values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun_err=0
  - state=IDLE, counters=0, sync flops=1
- rx passes through a 2-flop synchroniser to give rx_s; add 2 clk latency. All decisions use rx_s.
- All state, counter and sample updates occur only on clk edges where sample_tick=1. The handshake logic runs every clk.
- tick_cnt counts 0..SAMPLE_RATE-1 within a bit. Vote points are M-1, M, M+1 with M=SAMPLE_RATE/2 (4,5,6 for the default). The bit value is the majority of the three samples.
- IDLE:
  - On a tick with rx_s=0: tick_cnt←1 (the detection tick counts as sample 0); go to START.
- START:
  - Samples are collected at the vote points.
  - At tick_cnt=M+1: if the vote is 1 (false start/glitch) → IDLE.
  - At tick_cnt=SAMPLE_RATE-1: tick_cnt←0, bit_idx←0 → DATA.
- DATA:
  - At M+1, the voted bit shifts into the shift register MSB-side, so that after DATA_BITS bits bit0 sits at the LSB.
  - At SAMPLE_RATE-1: bit_idx++. After bit_idx=DATA_BITS-1 → STOP.
- STOP, at M+1 (evaluated mid-stop-bit, so receive resyncs half a bit early):
  - Vote=1, rx_valid=0 → rx_data←shift, rx_valid←1 on the next clk edge; go to IDLE.
  - Vote=1, rx_valid=1 (and no ack this cycle) → overrun_err pulse; rx_data keeps the old byte; new byte dropped; go to IDLE.
  - Vote=1, rx_ack=1 in the same clk → treat as not full: load new byte, rx_valid stays 1, no overrun.
  - Vote=0 → frame_err pulse, no data update → WAIT_HIGH.
- WAIT_HIGH: stay until a tick with rx_s=1 → IDLE. A break condition therefore yields exactly one frame_err.
- Handshake: rx_valid=1 and rx_ack=1 → rx_valid←0 next clk; rx_data unchanged. rx_ack while rx_valid=0 is ignored.
- Latency: rx_valid rises 1 clk after the tick carrying stop-bit sample M+1.
- sample_tick=0 indefinitely: state frozen; handshake still operates.
- Reset asserted mid-frame: immediate return to reset values; the partial byte is discarded.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, WAIT_HIGH)
  - default SAMPLE_RATE/DATA_BITS constants, matching the divider defaults
  - function computing M
- One natural sub-module, uart_bit_voter: holds the 3-sample register and majority logic, with inputs sample_en, rx_s, and tick_cnt, and output bit_val.
- The synchroniser stays inline.

Test Plan:
1. sample_tick every 4 clk; send 0xA5 (rx bits 0,1,0,1,0,0,1,0,1,1) → rx_valid=1, rx_data=0xA5 one clk after stop sample 6; rx_ack → rx_valid=0 next clk.
2. Glitch: rx low for 3 ticks then high → returns to IDLE at tick 6; no rx_valid or frame_err. A following 0x3C frame is received correctly.
3. Send 0x55 with stop bit=0 → one frame_err pulse; rx_valid stays 0. Hold rx low 30 ticks → no further pulses. Release, send 0x0F → rx_data=0x0F.
4. Send 0x11 and 0x22 back-to-back without ack → rx_data=0x11 retained; overrun_err pulses once. Repeat with rx_ack asserted in the stop-completion clk → rx_data=0x22, no overrun.
5. Single-sample glitch on data bit 3 at sample 5 of 0x00 → still 0x00 (majority vote). Glitch on samples 4 and 5 → 0x08.
6. Drive rst=0 asynchronously (between clk edges) mid data bit 4 → outputs reset immediately. Release; the next full frame 0xC3 is received correctly.
